// File: rtl/reg_wb_arbiter.sv
// Two-port register-file write-back arbiter with a load scoreboard.
// Port A is the execute stage, port B the load unit; B write-backs retire pending loads.
module reg_wb_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        issue_en,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        rs1_used,
  input  logic        rs2_used,
  output logic        stall,
  output logic        write_en,
  output logic [4:0]  write_addr,
  output logic [31:0] write_value,
  output logic        any_pending
);

  // last_grant: 0 = A, 1 = B
  logic        last_grant_q, last_grant_d;
  logic        write_en_q, write_en_d;
  logic [4:0]  write_addr_q, write_addr_d;
  logic [31:0] write_value_q, write_value_d;
  logic [31:0] pending_q, pending_d;

  logic        grant_a, grant_b, xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        if (PRIO_MODE == 1 || !last_grant_q) grant_b = 1'b1;
        else                                 grant_a = 1'b1;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign xfer     = grant_a | grant_b;
  assign sel_addr = grant_b ? b_addr : a_addr;
  assign sel_data = grant_b ? b_data : a_data;

  always_comb begin
    last_grant_d  = xfer ? grant_b : last_grant_q;
    write_en_d    = xfer && (sel_addr != 5'd0);
    write_addr_d  = xfer ? sel_addr : write_addr_q;
    write_value_d = xfer ? sel_data : write_value_q;
    // Clear before set so a same-cycle issue to the retiring register stays pending.
    pending_d = pending_q;
    if (grant_b) pending_d[b_addr] = 1'b0;
    if (issue_en && issue_addr != 5'd0) pending_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= 1'b0;
      write_en_q    <= 1'b0;
      write_addr_q  <= 5'd0;
      write_value_q <= 32'd0;
      pending_q     <= 32'd0;
    end else begin
      last_grant_q  <= last_grant_d;
      write_en_q    <= write_en_d;
      write_addr_q  <= write_addr_d;
      write_value_q <= write_value_d;
      pending_q     <= pending_d;
    end
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign stall       = (rs1_used && pending_q[rs1_addr]) || (rs2_used && pending_q[rs2_addr]);
  assign any_pending = |pending_q;
  assign write_en    = write_en_q;
  assign write_addr  = write_addr_q;
  assign write_value = write_value_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: instance 0 uses round-robin, instance 1 fixed B priority.
// Directed literal checks first, then random traffic against a behavioural model.
module tb_reg_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid [2];
  logic [4:0]  a_addr  [2];
  logic [31:0] a_data  [2];
  logic        a_ready [2];
  logic        b_valid [2];
  logic [4:0]  b_addr  [2];
  logic [31:0] b_data  [2];
  logic        b_ready [2];
  logic        issue_en [2];
  logic [4:0]  issue_addr [2];
  logic [4:0]  rs1_addr [2];
  logic [4:0]  rs2_addr [2];
  logic        rs1_used [2];
  logic        rs2_used [2];
  logic        stall [2];
  logic        write_en [2];
  logic [4:0]  write_addr [2];
  logic [31:0] write_value [2];
  logic        any_pending [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.PRIO_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .a_valid(a_valid[0]), .a_addr(a_addr[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
    .b_valid(b_valid[0]), .b_addr(b_addr[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
    .issue_en(issue_en[0]), .issue_addr(issue_addr[0]),
    .rs1_addr(rs1_addr[0]), .rs2_addr(rs2_addr[0]), .rs1_used(rs1_used[0]), .rs2_used(rs2_used[0]),
    .stall(stall[0]), .write_en(write_en[0]), .write_addr(write_addr[0]),
    .write_value(write_value[0]), .any_pending(any_pending[0])
  );

  reg_wb_arbiter #(.PRIO_MODE(1)) dut_fp (
    .clk(clk), .reset(reset),
    .a_valid(a_valid[1]), .a_addr(a_addr[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
    .b_valid(b_valid[1]), .b_addr(b_addr[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
    .issue_en(issue_en[1]), .issue_addr(issue_addr[1]),
    .rs1_addr(rs1_addr[1]), .rs2_addr(rs2_addr[1]), .rs1_used(rs1_used[1]), .rs2_used(rs2_used[1]),
    .stall(stall[1]), .write_en(write_en[1]), .write_addr(write_addr[1]),
    .write_value(write_value[1]), .any_pending(any_pending[1])
  );

  // Behavioural model state per instance
  logic [31:0] m_pend [2];
  logic        m_last_b [2];
  logic        m_we [2];
  logic [4:0]  m_wa [2];
  logic [31:0] m_wv [2];
  logic        ga_prev [2];
  logic        gb_prev [2];

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, inst, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 1'b0; a_addr[i] = '0; a_data[i] = '0;
      b_valid[i] = 1'b0; b_addr[i] = '0; b_data[i] = '0;
      issue_en[i] = 1'b0; issue_addr[i] = '0;
      rs1_addr[i] = '0; rs2_addr[i] = '0; rs1_used[i] = 1'b0; rs2_used[i] = 1'b0;
    end
  endtask

  initial begin
    clr_all();
    reset = 1'b1;
    // Requests and issue during reset must be ignored
    a_valid[0] = 1'b1; b_valid[0] = 1'b1; issue_en[0] = 1'b1; issue_addr[0] = 5'd3;
    tick(); #1;
    chk("rst_a_ready", 0, a_ready[0], 0);
    chk("rst_b_ready", 0, b_ready[0], 0);
    tick(); clr_all(); reset = 1'b0; #1;
    chk("rst_write_en", 0, write_en[0], 0);
    chk("rst_write_addr", 0, write_addr[0], 0);
    chk("rst_write_value", 0, write_value[0], 0);
    chk("rst_any_pending", 0, any_pending[0], 0);

    // Lone A request
    a_valid[0] = 1'b1; a_addr[0] = 5'd5; a_data[0] = 32'hDEADBEEF; #1;
    chk("loneA_a_ready", 0, a_ready[0], 1);
    chk("loneA_b_ready", 0, b_ready[0], 0);
    tick(); a_valid[0] = 1'b0; #1;
    chk("loneA_we", 0, write_en[0], 1);
    chk("loneA_wa", 0, write_addr[0], 5);
    chk("loneA_wv", 0, write_value[0], 32'hDEADBEEF);
    tick(); #1;
    chk("idle_we", 0, write_en[0], 0);
    chk("idle_wa_hold", 0, write_addr[0], 5);
    chk("idle_wv_hold", 0, write_value[0], 32'hDEADBEEF);

    // Round-robin conflict: last grant was A, so B first
    a_valid[0] = 1'b1; a_addr[0] = 5'd3; a_data[0] = 32'h11;
    b_valid[0] = 1'b1; b_addr[0] = 5'd4; b_data[0] = 32'h22; #1;
    chk("rr1_b_ready", 0, b_ready[0], 1);
    chk("rr1_a_ready", 0, a_ready[0], 0);
    tick(); b_valid[0] = 1'b0; #1;
    chk("rr1_wa", 0, write_addr[0], 4);
    chk("rr1_wv", 0, write_value[0], 32'h22);
    chk("rr2_a_ready", 0, a_ready[0], 1);
    tick(); a_valid[0] = 1'b0; #1;
    chk("rr2_wa", 0, write_addr[0], 3);
    chk("rr2_wv", 0, write_value[0], 32'h11);

    // Scoreboard set / stall / clear
    issue_en[0] = 1'b1; issue_addr[0] = 5'd7; rs1_addr[0] = 5'd7; rs1_used[0] = 1'b0; #1;
    chk("sb_stall_pre", 0, stall[0], 0);
    tick(); issue_en[0] = 1'b0; #1;
    chk("sb_any", 0, any_pending[0], 1);
    chk("sb_stall_unused", 0, stall[0], 0);
    rs1_used[0] = 1'b1; #1;
    chk("sb_stall", 0, stall[0], 1);
    b_valid[0] = 1'b1; b_addr[0] = 5'd7; b_data[0] = 32'h77; #1;
    chk("sb_b_ready", 0, b_ready[0], 1);
    chk("sb_stall_hold", 0, stall[0], 1);
    tick(); b_valid[0] = 1'b0; #1;
    chk("sb_stall_clr", 0, stall[0], 0);
    chk("sb_any_clr", 0, any_pending[0], 0);
    rs1_used[0] = 1'b0;

    // x0 write suppressed, set wins over clear
    b_valid[0] = 1'b1; b_addr[0] = 5'd0; b_data[0] = 32'h55; #1;
    chk("x0_b_ready", 0, b_ready[0], 1);
    tick(); b_valid[0] = 1'b0; #1;
    chk("x0_we", 0, write_en[0], 0);
    chk("x0_wa", 0, write_addr[0], 0);
    chk("x0_wv", 0, write_value[0], 32'h55);
    issue_en[0] = 1'b1; issue_addr[0] = 5'd9;
    b_valid[0] = 1'b1; b_addr[0] = 5'd9; b_data[0] = 32'h99; #1;
    chk("setwin_b_ready", 0, b_ready[0], 1);
    tick(); issue_en[0] = 1'b0; b_valid[0] = 1'b0;
    rs2_addr[0] = 5'd9; rs2_used[0] = 1'b1; #1;
    chk("setwin_stall", 0, stall[0], 1);
    chk("setwin_any", 0, any_pending[0], 1);
    chk("setwin_wa", 0, write_addr[0], 9);

    // Reset mid-operation with pending {7,9} and an A write in flight
    rs2_used[0] = 1'b0; issue_en[0] = 1'b1; issue_addr[0] = 5'd7;
    tick(); issue_en[0] = 1'b0;
    a_valid[0] = 1'b1; a_addr[0] = 5'd12; a_data[0] = 32'hABC; #1;
    chk("mid_a_ready", 0, a_ready[0], 1);
    tick(); reset = 1'b1; b_valid[0] = 1'b1; #1;
    chk("mid_inflight_we", 0, write_en[0], 1);
    chk("mid_rst_a_ready", 0, a_ready[0], 0);
    chk("mid_rst_b_ready", 0, b_ready[0], 0);
    chk("mid_any_before", 0, any_pending[0], 1);
    tick(); #1;
    chk("mid_we_after", 0, write_en[0], 0);
    chk("mid_any_after", 0, any_pending[0], 0);
    clr_all(); reset = 1'b0;

    // Fixed priority: B wins every cycle, A starved
    for (int k = 0; k < 3; k++) begin
      a_valid[1] = 1'b1; a_addr[1] = 5'd3; a_data[1] = 32'h11;
      b_valid[1] = 1'b1; b_addr[1] = 5'(10 + k); b_data[1] = 32'(k); #1;
      chk("fp_b_ready", 1, b_ready[1], 1);
      chk("fp_a_ready", 1, a_ready[1], 0);
      tick(); #1;
      chk("fp_wa", 1, write_addr[1], 32'(10 + k));
    end
    clr_all();

    // Random traffic against the model
    reset = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = '0; m_last_b[i] = 1'b0; m_we[i] = 1'b0; m_wa[i] = '0; m_wv[i] = '0;
      ga_prev[i] = 1'b0; gb_prev[i] = 1'b0;
    end
    reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(a_valid[i] && !ga_prev[i])) begin
          a_valid[i] = 1'($urandom_range(0, 1));
          a_addr[i]  = 5'($urandom_range(0, 15));
          a_data[i]  = $urandom;
        end
        if (!(b_valid[i] && !gb_prev[i])) begin
          b_valid[i] = 1'($urandom_range(0, 1));
          b_addr[i]  = 5'($urandom_range(0, 15));
          b_data[i]  = $urandom;
        end
        issue_en[i]   = ($urandom_range(0, 3) == 0);
        issue_addr[i] = 5'($urandom_range(0, 15));
        rs1_addr[i]   = 5'($urandom_range(0, 15));
        rs2_addr[i]   = 5'($urandom_range(0, 15));
        rs1_used[i]   = 1'($urandom_range(0, 1));
        rs2_used[i]   = 1'($urandom_range(0, 1));
      end
      reset = ($urandom_range(0, 99) == 0);
      #1;
      for (int i = 0; i < 2; i++) begin
        logic ea, eb, est;
        ea = 1'b0; eb = 1'b0;
        if (!reset) begin
          if (a_valid[i] && b_valid[i]) begin
            // instance 1 always favours B; instance 0 alternates away from last winner
            eb = (i == 1) || !m_last_b[i];
            ea = !eb;
          end else begin
            ea = a_valid[i]; eb = b_valid[i];
          end
        end
        est = (rs1_used[i] && m_pend[i][rs1_addr[i]]) || (rs2_used[i] && m_pend[i][rs2_addr[i]]);
        chk("rnd_a_ready", i, a_ready[i], ea);
        chk("rnd_b_ready", i, b_ready[i], eb);
        chk("rnd_stall", i, stall[i], est);
        chk("rnd_any_pending", i, any_pending[i], (m_pend[i] != 0));
        chk("rnd_write_en", i, write_en[i], m_we[i]);
        chk("rnd_write_addr", i, write_addr[i], m_wa[i]);
        chk("rnd_write_value", i, write_value[i], m_wv[i]);
        if (reset) begin
          m_pend[i] = '0; m_last_b[i] = 1'b0; m_we[i] = 1'b0; m_wa[i] = '0; m_wv[i] = '0;
        end else begin
          if (eb) m_pend[i][b_addr[i]] = 1'b0;
          if (issue_en[i] && issue_addr[i] != 0) m_pend[i][issue_addr[i]] = 1'b1;
          if (ea || eb) begin
            m_last_b[i] = eb;
            m_wa[i] = eb ? b_addr[i] : a_addr[i];
            m_wv[i] = eb ? b_data[i] : a_data[i];
            m_we[i] = (m_wa[i] != 0);
          end else begin
            m_we[i] = 1'b0;
          end
        end
        ga_prev[i] = ea;
        gb_prev[i] = eb;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter PRIO_MODE, default 0, conflict policy: 0 round-robin, 1 fixed priority to port B.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port a_valid  input  1  execute-stage write-back request.
REQ-005 SHALL have port a_addr  input  5  destination register for A.
REQ-006 SHALL have port a_data  input  32  write value for A.
REQ-007 SHALL have port a_ready  output  1  A request accepted this cycle.
REQ-008 SHALL have port b_valid  input  1  load-unit write-back request.
REQ-009 SHALL have port b_addr  input  5  destination register for B.
REQ-010 SHALL have port b_data  input  32  write value for B.
REQ-011 SHALL have port b_ready  output  1  B request accepted this cycle.
REQ-012 SHALL have port issue_en  input  1  decode issued a load; mark destination pending.
REQ-013 SHALL have port issue_addr  input  5  load destination register.
REQ-014 SHALL have ports rs1_addr, rs2_addr  input  5 each  decode source registers.
REQ-015 SHALL have ports rs1_used, rs2_used  input  1 each  source actually read.
REQ-016 SHALL have port stall  output  1  decode must hold (pending source).
REQ-017 SHALL have ports write_en  output  1, write_addr  output  5, write_value  output  32  register-file write port.
REQ-018 SHALL have port any_pending  output  1  at least one load outstanding.

Function
REQ-019 Transfer SHALL occur on a port when valid && ready at a rising edge; requester SHALL hold valid/addr/data stable until ready.
REQ-020 a_ready/b_ready SHALL be combinational; exactly one at most asserted; a lone valid requester SHALL be granted in the same cycle.
REQ-021 Both valid, PRIO_MODE=0: grant the port not in last_grant; last_grant SHALL update to the granted port on every transfer.
REQ-022 Both valid, PRIO_MODE=1: grant B; last_grant still updates.
REQ-023 Write port SHALL be registered, latency 1: cycle after a transfer, write_en=1, write_addr/write_value = accepted addr/data.
REQ-024 No transfer in a cycle SHALL give write_en=0 next cycle; write_addr/write_value hold previous values.
REQ-025 Transfer with addr 0 SHALL be accepted (ready asserted) but SHALL produce write_en=0; addr/value registers still load.
REQ-026 Scoreboard: 32-bit pending vector; issue_en SHALL set pending[issue_addr]; B transfer SHALL clear pending[b_addr]; both visible next cycle.
REQ-027 issue_addr 0 SHALL never set pending[0]; pending[0] constant 0.
REQ-028 Simultaneous issue_en and B transfer to the same address SHALL leave the bit set (set wins).
REQ-029 issue_en to an already-pending address SHALL leave it set; no counting.
REQ-030 A transfers SHALL not affect pending.
REQ-031 stall SHALL be combinational: (rs1_used && pending[rs1_addr]) || (rs2_used && pending[rs2_addr]).
REQ-032 any_pending SHALL be the OR of the pending vector.

Reset
REQ-033 With reset high at a rising edge: pending=0, last_grant=A, write_en=0, write_addr=0, write_value=0.
REQ-034 During reset a_ready=b_ready=0; no transfer, no scoreboard update; issue_en ignored.
REQ-035 Reset asserted mid-operation SHALL discard any in-flight write (write_en=0 next cycle) and all pending bits.

Verification
REQ-036 Lone A: a_valid=1, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle write_en=1, write_addr=5, write_value=0xDEADBEEF.
REQ-037 Conflict, PRIO_MODE=0, from reset: A(3,0x11), B(4,0x22) held valid -> B granted first, A second; write_addr 4 then 3 on consecutive cycles.
REQ-038 Conflict, PRIO_MODE=1: both valid 3 cycles with B re-presenting each cycle -> B granted every cycle, A starved, a_ready=0.
REQ-039 Scoreboard: issue_en addr 7 -> next cycle rs1_addr=7, rs1_used=1 gives stall=1, any_pending=1; B transfer addr 7 -> stall=0 the following cycle; rs1_used=0 -> stall=0 throughout.
REQ-040 x0 and corner: B transfer addr 0 -> b_ready=1, write_en=0; issue_en and B transfer both addr 9 same cycle -> pending[9]=1 after.
REQ-041 Reset mid-op: pending {7,9}, A transfer in flight, reset pulse -> next cycle write_en=0, any_pending=0, a_ready=b_ready=0 while reset high.
